mux_8x1: RTL and testbench

MUX_8X1 -- requirements
Module: mux_8x1

---
 rtl/mux_8x1.sv | 92 +++++++++
 tb/tb_mux_8x1.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_8x1.sv
// 8:1 lane multiplexer built from a three-level tree of 2:1 cells, with an
// optional output register (synchronous active-high reset) selected by REG_OUT.

module mux_2x1 #(
    parameter int unsigned DATA_W = 1
) (
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic              sel,
    output logic [DATA_W-1:0] y_c
);

    assign y_c = sel ? in1 : in0;

endmodule

module mux_8x1 #(
    parameter int unsigned DATA_W  = 1,
    parameter int unsigned REG_OUT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*DATA_W-1:0]   a,
    input  logic [2:0]            s,
    input  logic                  vld_in,
    output logic [DATA_W-1:0]     y,
    output logic                  vld_out
);

    localparam int unsigned NUM_L1 = 4;
    localparam int unsigned NUM_L2 = 2;

    logic [DATA_W-1:0] l1_c [NUM_L1];
    logic [DATA_W-1:0] l2_c [NUM_L2];
    logic [DATA_W-1:0] tree_c;

    // Level 1: adjacent lane pairs steered by s[0]
    for (genvar i = 0; i < NUM_L1; i++) begin : g_l1
        mux_2x1 #(.DATA_W(DATA_W)) u_cell (
            .in0 (a[(2*i)*DATA_W   +: DATA_W]),
            .in1 (a[(2*i+1)*DATA_W +: DATA_W]),
            .sel (s[0]),
            .y_c (l1_c[i])
        );
    end

    for (genvar j = 0; j < NUM_L2; j++) begin : g_l2
        mux_2x1 #(.DATA_W(DATA_W)) u_cell (
            .in0 (l1_c[2*j]),
            .in1 (l1_c[2*j+1]),
            .sel (s[1]),
            .y_c (l2_c[j])
        );
    end

    mux_2x1 #(.DATA_W(DATA_W)) u_l3 (
        .in0 (l2_c[0]),
        .in1 (l2_c[1]),
        .sel (s[2]),
        .y_c (tree_c)
    );

    if (REG_OUT != 0) begin : g_reg
        logic [DATA_W-1:0] y_d;
        logic [DATA_W-1:0] y_q;
        logic              vld_d;
        logic              vld_q;

        always_comb begin
            y_d   = tree_c;
            vld_d = vld_in;
        end

        // Data register loads every cycle; vld_in only qualifies it downstream
        always_ff @(posedge clk) begin
            if (rst) begin
                y_q   <= '0;
                vld_q <= 1'b0;
            end else begin
                y_q   <= y_d;
                vld_q <= vld_d;
            end
        end

        assign y       = y_q;
        assign vld_out = vld_q;
    end else begin : g_comb
        assign y       = tree_c;
        assign vld_out = vld_in;
    end

endmodule

// File: tb/tb_mux_8x1.sv
// Scoreboard bench for mux_8x1: registered 1-bit, registered 8-bit and
// combinational 1-bit instances, checked by a negedge monitor with due cycles.

module tb_mux_8x1;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_c = 1'b0;

    logic [7:0]  a1 = '0;
    logic [2:0]  s1 = '0;
    logic        v1 = 1'b0;
    logic        y1;
    logic        vo1;

    logic [63:0] a8 = '0;
    logic [2:0]  s8 = '0;
    logic        v8 = 1'b0;
    logic [7:0]  y8;
    logic        vo8;

    logic [7:0]  ac = '0;
    logic [2:0]  sc = '0;
    logic        vc = 1'b0;
    logic        yc;
    logic        voc;

    exp_t q1[$];
    exp_t q8[$];
    exp_t qc[$];

    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    logic chk_rst = 1'b0;
    logic chk_end = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mux_8x1 #(.DATA_W(1), .REG_OUT(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .s(s1), .vld_in(v1), .y(y1), .vld_out(vo1)
    );

    mux_8x1 #(.DATA_W(8), .REG_OUT(1)) u_dut8 (
        .clk(clk), .rst(rst), .a(a8), .s(s8), .vld_in(v8), .y(y8), .vld_out(vo8)
    );

    mux_8x1 #(.DATA_W(1), .REG_OUT(0)) u_dutc (
        .clk(clk), .rst(rst_c), .a(ac), .s(sc), .vld_in(vc), .y(yc), .vld_out(voc)
    );

    // Monitor: pops expected results whenever a DUT raises vld_out
    always @(negedge clk) begin
        exp_t e;
        if (chk_rst) begin
            checks++;
            if (y1 !== 1'b0 || vo1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_w1: y=%b vld_out=%b, want y=0 vld_out=0", y1, vo1);
            end
            checks++;
            if (y8 !== 8'h00 || vo8 !== 1'b0) begin
                errors++;
                $display("FAIL reset_w8: y=%h vld_out=%b, want y=00 vld_out=0", y8, vo8);
            end
        end
        if (q1.size() > 0 && q1[0].due < cyc) begin
            e = q1.pop_front();
            checks++; errors++;
            $display("FAIL missing_w1: no vld_out by cycle %0d, want y=%h", e.due, e.data);
        end
        if (vo1 !== 1'b0) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL spurious_w1: vld_out=%b y=%b at cycle %0d, want vld_out=0", vo1, y1, cyc);
            end else begin
                e = q1.pop_front();
                if ({7'b0, y1} !== e.data || vo1 !== 1'b1 || cyc != e.due) begin
                    errors++;
                    $display("FAIL data_w1: y=%b at cycle %0d, want y=%b at cycle %0d", y1, cyc, e.data[0], e.due);
                end
            end
        end
        if (q8.size() > 0 && q8[0].due < cyc) begin
            e = q8.pop_front();
            checks++; errors++;
            $display("FAIL missing_w8: no vld_out by cycle %0d, want y=%h", e.due, e.data);
        end
        if (vo8 !== 1'b0) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL spurious_w8: vld_out=%b y=%h at cycle %0d, want vld_out=0", vo8, y8, cyc);
            end else begin
                e = q8.pop_front();
                if (y8 !== e.data || vo8 !== 1'b1 || cyc != e.due) begin
                    errors++;
                    $display("FAIL data_w8: y=%h at cycle %0d, want y=%h at cycle %0d", y8, cyc, e.data, e.due);
                end
            end
        end
        if (qc.size() > 0 && qc[0].due < cyc) begin
            e = qc.pop_front();
            checks++; errors++;
            $display("FAIL missing_comb: no vld_out by cycle %0d, want y=%h", e.due, e.data);
        end
        if (voc !== 1'b0) begin
            checks++;
            if (qc.size() == 0) begin
                errors++;
                $display("FAIL spurious_comb: vld_out=%b y=%b at cycle %0d, want vld_out=0", voc, yc, cyc);
            end else begin
                e = qc.pop_front();
                if ({7'b0, yc} !== e.data || voc !== 1'b1 || cyc != e.due) begin
                    errors++;
                    $display("FAIL data_comb: y=%b at cycle %0d, want y=%b at cycle %0d", yc, cyc, e.data[0], e.due);
                end
            end
        end
        if (chk_end) begin
            checks++;
            if (q1.size() + q8.size() + qc.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d results outstanding, want 0", q1.size() + q8.size() + qc.size());
            end
        end
    end

    task automatic step1(input logic [7:0] a, input logic [2:0] s, input logic v, input logic e);
        @(posedge clk); #1;
        a1 = a; s1 = s; v1 = v;
        if (v && !rst) q1.push_back('{data: {7'b0, e}, due: cyc + 1});
    endtask

    task automatic step8(input logic [63:0] a, input logic [2:0] s, input logic [7:0] e);
        @(posedge clk); #1;
        a8 = a; s8 = s; v8 = 1'b1;
        q8.push_back('{data: e, due: cyc + 1});
    endtask

    task automatic stepc(input logic [7:0] a, input logic [2:0] s, input logic r, input logic e);
        @(posedge clk); #1;
        ac = a; sc = s; vc = 1'b1; rst_c = r;
        qc.push_back('{data: {7'b0, e}, due: cyc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        sweep_exp [8];
        logic [63:0] wide_a;
        sweep_exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        // Initial reset: two edges with rst high, checked after each
        @(posedge clk); #1; chk_rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1; chk_rst = 1'b0;

        // Select sweep on a = 8'b00011001
        for (int i = 0; i < 8; i++) step1(8'b0001_1001, 3'(i), 1'b1, sweep_exp[i]);
        step1(8'b0001_1001, 3'd0, 1'b0, 1'b0);

        // Reset overrides live inputs; first result one cycle after release
        @(posedge clk); #1; rst = 1'b1; a1 = 8'hFF; s1 = 3'd7; v1 = 1'b1;
        @(posedge clk); #1; chk_rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        q1.push_back('{data: 8'h01, due: cyc + 1});
        @(posedge clk); #1; chk_rst = 1'b0; v1 = 1'b0;

        // Walking one: hit on s=k, miss on s=k+1
        for (int k = 0; k < 8; k++) begin
            step1(8'(1 << k), 3'(k), 1'b1, 1'b1);
            step1(8'(1 << k), 3'((k + 1) % 8), 1'b1, 1'b0);
        end

        // a and s change on the same edge
        step1(8'h01, 3'd0, 1'b1, 1'b1);
        step1(8'h80, 3'd7, 1'b1, 1'b1);
        step1(8'h80, 3'd7, 1'b0, 1'b0);

        // Wide lanes: lane i = 8'h10 + i
        wide_a = 64'h1716_1514_1312_1110;
        step8(wide_a, 3'd0, 8'h10);
        step8(wide_a, 3'd1, 8'h11);
        step8(wide_a, 3'd2, 8'h12);
        step8(wide_a, 3'd3, 8'h13);
        step8(wide_a, 3'd4, 8'h14);
        step8(wide_a, 3'd5, 8'h15);
        step8(wide_a, 3'd6, 8'h16);
        step8(wide_a, 3'd7, 8'h17);
        @(posedge clk); #1; v8 = 1'b0;

        // Combinational mode: same-cycle result, rst toggling is ignored
        for (int i = 0; i < 8; i++) stepc(8'b0001_1001, 3'(i), 1'(i % 2), sweep_exp[i]);
        stepc(8'b0001_1001, 3'd4, 1'b1, 1'b1);
        stepc(8'b0001_1001, 3'd4, 1'b0, 1'b1);
        @(posedge clk); #1; vc = 1'b0; rst_c = 1'b0;

        repeat (3) @(posedge clk);
        #1; chk_end = 1'b1;
        @(negedge clk); #1;
        chk_end = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
